// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory arbiter: FSM states, port
// identifiers, the request bundle and the read-latency bound.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        LOCKED  = 2'd2
    } arb_state_e;

    typedef enum logic {
        P_CORE   = 1'b0,
        P_LOADER = 1'b1
    } port_id_e;

    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX + 1);

    // Widest supported request; narrower instances zero-fill the upper bits.
    localparam int unsigned REQ_ADDR_MAX = 64;
    localparam int unsigned REQ_DATA_MAX = 64;
    localparam int unsigned REQ_MASK_MAX = REQ_DATA_MAX / 8;

    typedef struct packed {
        logic                    we;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] wdata;
        logic [REQ_MASK_MAX-1:0] wmask;
    } arb_req_t;

endpackage

// File: rtl/mem_rd_tracker.sv
// Tracks the single outstanding memory read: latency countdown and the port
// that owns the returning data.
module mem_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     start,
    input  port_id_e start_owner,
    output logic     rd_done,
    output logic     rd_remain,
    output port_id_e rd_owner
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            rd_owner <= P_CORE;
        end else if (start) begin
            // A new read may launch on the completion cycle of the previous one.
            count    <= CNT_W'(RD_LAT);
            rd_owner <= start_owner;
        end else if (count != '0) begin
            count    <= count - CNT_W'(1);
        end
    end

    always_comb begin
        rd_done   = (count == CNT_W'(1));
        rd_remain = (count > CNT_W'(1));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter between the core (p0) and the loader/debug port (p1) for
// the shared single-port memory, with loader lock and read-response routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    output logic                p0_gnt,
    output logic                p0_rvalid,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    output logic                p1_gnt,
    output logic                p1_rvalid,
    output logic [DATA_W-1:0]   p1_rdata,
    input  logic                p1_lock,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_e state, state_n;
    port_id_e   last_gnt, rd_owner, rd_start_owner;
    logic       lock_own, lock_own_n;
    logic       open_win, cand0, cand1;
    logic       rd_start, rd_done, rd_remain;
    arb_req_t   req0, req1, sel;
    logic       unused_sel;

    // Grants are combinational from req and registered state: zero added latency.
    always_comb begin
        open_win = reset && ((state != RD_WAIT) || rd_done);
        cand0    = p0_req && open_win && !lock_own;
        cand1    = p1_req && open_win;
        p0_gnt   = cand0 && !(cand1 && (last_gnt == P_CORE));
        p1_gnt   = cand1 && !(cand0 && (last_gnt == P_LOADER));
    end

    always_comb begin
        rd_start       = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
        rd_start_owner = p1_gnt ? P_LOADER : P_CORE;
        // Lock is owned from a locked p1 grant until p1_lock drops with no read in flight.
        lock_own_n     = (p1_gnt && p1_lock) ||
                         (lock_own && (p1_lock || rd_start || rd_remain));
        if (rd_start || rd_remain) begin
            state_n = RD_WAIT;
        end else if (lock_own_n) begin
            state_n = LOCKED;
        end else begin
            state_n = IDLE;
        end
    end

    mem_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk         (clk),
        .reset       (reset),
        .start       (rd_start),
        .start_owner (rd_start_owner),
        .rd_done     (rd_done),
        .rd_remain   (rd_remain),
        .rd_owner    (rd_owner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_gnt <= P_LOADER;
            lock_own <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            lock_own <= lock_own_n;
            busy     <= (state_n != IDLE);
            if (p0_gnt) begin
                last_gnt <= P_CORE;
            end else if (p1_gnt) begin
                last_gnt <= P_LOADER;
            end
        end
    end

    always_comb begin
        req0                    = '0;
        req0.we                 = p0_we;
        req0.addr[ADDR_W-1:0]   = p0_addr;
        req0.wdata[DATA_W-1:0]  = p0_wdata;
        req0.wmask[MASK_W-1:0]  = p0_wmask;
        req1                    = '0;
        req1.we                 = p1_we;
        req1.addr[ADDR_W-1:0]   = p1_addr;
        req1.wdata[DATA_W-1:0]  = p1_wdata;
        req1.wmask[MASK_W-1:0]  = p1_wmask;
        sel = '0;
        if (p0_gnt) begin
            sel = req0;
        end else if (p1_gnt) begin
            sel = req1;
        end
    end

    always_comb begin
        mem_en    = p0_gnt || p1_gnt;
        mem_we    = sel.we;
        mem_addr  = sel.addr[ADDR_W-1:2];
        mem_wdata = sel.wdata[DATA_W-1:0];
        mem_wmask = sel.wmask[MASK_W-1:0];
    end

    always_comb begin
        p0_rvalid = rd_done && (rd_owner == P_CORE);
        p1_rvalid = rd_done && (rd_owner == P_LOADER);
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
    end

    // Byte-offset bits and zero-filled upper request bits are intentionally dropped.
    assign unused_sel = ^sel;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: main instance at RD_LAT=2, a second at
// RD_LAT=3 for the reset-during-read scenario.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk, rst_n, rst3_n;
    logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_en, mem_we, busy;
    logic [31:0] p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wmask;

    logic        q0_req, q0_we, q1_req, q1_we;
    logic [31:0] q0_addr, q1_addr;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, r_en, r_we, r_busy;
    logic [31:0] r0_rdata, r1_rdata, r_wdata;
    logic [29:0] r_addr;
    logic [3:0]  r_wmask;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem_img [0:255];
    logic [31:0] ref_img [0:255];
    logic [31:0] pipe0, pipe1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT)) u_dut (
        .clk(clk), .reset(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wmask(p0_wmask), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wmask(p1_wmask), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_lock(p1_lock), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst3_n),
        .p0_req(q0_req), .p0_we(q0_we), .p0_addr(q0_addr), .p0_wdata(32'h0),
        .p0_wmask(4'h0), .p0_gnt(r0_gnt), .p0_rvalid(r0_rvalid), .p0_rdata(r0_rdata),
        .p1_req(q1_req), .p1_we(q1_we), .p1_addr(q1_addr), .p1_wdata(32'h0),
        .p1_wmask(4'h0), .p1_gnt(r1_gnt), .p1_rvalid(r1_rvalid), .p1_rdata(r1_rdata),
        .p1_lock(1'b0), .mem_en(r_en), .mem_we(r_we), .mem_addr(r_addr),
        .mem_wdata(r_wdata), .mem_wmask(r_wmask), .mem_rdata(32'h0BAD_F00D), .busy(r_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory model: word array with LAT=2 read pipeline.
    always @(posedge clk) begin
        if (mem_en && mem_we)
            mem_img[mem_addr[7:0]] <= merge(mem_img[mem_addr[7:0]], mem_wdata, mem_wmask);
        pipe0 <= (mem_en && !mem_we) ? mem_img[mem_addr[7:0]] : 32'h0;
        pipe1 <= pipe0;
    end
    assign mem_rdata = pipe1;

    // Scoreboard: responses popped first, then this cycle's accepted reads pushed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_rvalid || p1_rvalid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rv_port", {p1_rvalid, p0_rvalid}, e.port ? 2'b10 : 2'b01);
                    check("rv_data", e.port ? p1_rdata : p0_rdata, e.data);
                    check("rv_cycle", cyc, e.due);
                end
            end
            if (!p0_rvalid) check("p0_rdata_idle", p0_rdata, 0);
            if (!p1_rvalid) check("p1_rdata_idle", p1_rdata, 0);
            if (p0_gnt) begin
                if (p0_we) ref_img[p0_addr[9:2]] = merge(ref_img[p0_addr[9:2]], p0_wdata, p0_wmask);
                else sb.push_back('{1'b0, ref_img[p0_addr[9:2]], cyc + LAT});
            end
            if (p1_gnt) begin
                if (p1_we) ref_img[p1_addr[9:2]] = merge(ref_img[p1_addr[9:2]], p1_wdata, p1_wmask);
                else sb.push_back('{1'b1, ref_img[p1_addr[9:2]], cyc + LAT});
            end
        end
    end

    property hold_req(logic req, logic gnt);
        @(posedge clk) disable iff (!rst_n) (req && !gnt) |=> req;
    endproperty
    a_p0_hold: assert property (hold_req(p0_req, p0_gnt)) else $error("FAIL p0_req dropped before grant");
    a_p1_hold: assert property (hold_req(p1_req, p1_gnt)) else $error("FAIL p1_req dropped before grant");

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_img[i] = 32'hC0DE_0000 | i;
            ref_img[i] = 32'hC0DE_0000 | i;
        end
        mem_img[4]  = 32'hDEAD_BEEF;  ref_img[4]  = 32'hDEAD_BEEF;
        mem_img[16] = 32'h1234_5678;  ref_img[16] = 32'h1234_5678;
        rst_n = 1'b0; rst3_n = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0000_0010; p0_wdata = '0; p0_wmask = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wmask = '0; p1_lock = 1'b0;
        q0_req = 1'b0; q0_we = 1'b0; q0_addr = '0; q1_req = 1'b0; q1_we = 1'b0; q1_addr = '0;

        // Reset: every output held at zero even with a request pending.
        tick();
        settle();
        check("rst_ctrl", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_en, mem_we, busy}, 7'h0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
        check("rst_mem", {mem_addr, mem_wmask}, 34'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        tick();
        rst_n = 1'b1; rst3_n = 1'b1;

        // Single core read at 0x10.
        settle();
        check("t1_gnt", {p0_gnt, p1_gnt, mem_en, mem_we}, 4'b1010);
        check("t1_mem_addr", mem_addr, 30'h4);
        tick();
        p0_req = 1'b0;
        settle();
        check("t1_wait", {p0_rvalid, p1_rvalid, busy}, 3'b001);
        tick();
        settle();
        check("t1_rvalid", {p0_rvalid, p1_rvalid}, 2'b10);
        check("t1_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();

        // Both ports read from reset: p0 first, p1 on p0's response cycle.
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h24;
        settle();
        check("t2_first", {p0_gnt, p1_gnt}, 2'b10);
        tick();
        p0_req = 1'b0;
        settle();
        check("t2_stall", p1_gnt, 1'b0);
        tick();
        settle();
        check("t2_b2b", {p0_rvalid, p1_gnt}, 2'b11);
        tick();
        p1_req = 1'b0;
        tick();
        settle();
        check("t2_p1_rvalid", {p1_rvalid, p1_rdata}, {1'b1, 32'hC0DE_0009});
        tick();

        // Loader locked burst of 4 writes while the core waits with a read.
        p1_req = 1'b1; p1_we = 1'b1; p1_lock = 1'b1; p1_wmask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            p1_addr  = 32'h100 + 4 * i;
            p1_wdata = 32'h11 * (i + 1);
            if (i == 1) begin
                p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h104;
            end
            settle();
            check("t3_lock_gnt", {p0_gnt, p1_gnt, mem_we}, 3'b011);
            check("t3_lock_addr", mem_addr, (32'h100 + 4 * i) >> 2);
            check("t3_lock_wdata", mem_wdata, 32'h11 * (i + 1));
            tick();
        end
        p1_req = 1'b0; p1_lock = 1'b0; p1_we = 1'b0;
        settle();
        check("t3_drop_cycle", {p0_gnt, busy}, 2'b01);
        tick();
        settle();
        check("t3_release", p0_gnt, 1'b1);
        tick();
        p0_req = 1'b0;
        tick();
        tick();

        // Byte-lane write passes mask/data unchanged; readback shows the merge.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wmask = 4'b0100; p0_wdata = 32'h00AB_0000;
        settle();
        check("t6_wmask", {p0_gnt, mem_we, mem_wmask}, 6'b11_0100);
        check("t6_wdata", mem_wdata, 32'h00AB_0000);
        check("t6_addr", mem_addr, 30'h10);
        tick();
        p0_we = 1'b0;
        settle();
        check("t6_rd_gnt", p0_gnt, 1'b1);
        tick();
        p0_req = 1'b0;
        tick();
        settle();
        check("t6_merge", {p0_rvalid, p0_rdata}, {1'b1, 32'h12AB_5678});
        tick();

        // Continuous write contention alternates one grant per cycle.
        do_reset();
        p0_req = 1'b1; p0_we = 1'b1; p0_wmask = 4'hF; p0_addr = 32'h80; p0_wdata = 32'hA0;
        p1_req = 1'b1; p1_we = 1'b1; p1_wmask = 4'hF; p1_addr = 32'hC0; p1_wdata = 32'hB0;
        for (int k = 0; k < 6; k++) begin
            settle();
            check("t4_alt", {p0_gnt, p1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            if (k % 2 == 0) begin
                p0_addr = p0_addr + 4; p0_wdata = p0_wdata + 1;
            end else begin
                p1_addr = p1_addr + 4; p1_wdata = p1_wdata + 1;
            end
        end
        p1_req = 1'b0;
        settle();
        check("t4_tail", {p0_gnt, p1_gnt}, 2'b10);
        tick();
        p0_req = 1'b0;

        // Reset in the middle of a p1 read on the RD_LAT=3 instance.
        q1_req = 1'b1; q1_we = 1'b0; q1_addr = 32'h30;
        settle();
        check("t5_p1_gnt", r1_gnt, 1'b1);
        tick();
        rst3_n = 1'b0;
        q1_req = 1'b1; q0_req = 1'b1; q0_we = 1'b0; q0_addr = 32'h34;
        for (int c = 1; c <= 2; c++) begin
            settle();
            check("t5_rst_ctrl", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r_en, r_we, r_busy}, 7'h0);
            check("t5_rst_data", {r0_rdata, r1_rdata, r_wdata}, 96'h0);
            check("t5_rst_mem", {r_addr, r_wmask}, 34'h0);
            tick();
        end
        rst3_n = 1'b1;
        settle();
        check("t5_tie", {r0_gnt, r1_gnt, r1_rvalid}, 3'b100);
        tick();
        q0_req = 1'b0;
        for (int c = 4; c <= 9; c++) begin
            settle();
            check("t5_post", {r0_rvalid, r1_gnt, r1_rvalid},
                  (c == 6) ? 3'b110 : (c == 9) ? 3'b001 : 3'b000);
            if (c == 6) check("t5_p0_data", r0_rdata, 32'h0BAD_F00D);
            if (c == 9) check("t5_p1_data", r1_rdata, 32'h0BAD_F00D);
            tick();
            if (c == 6) q1_req = 1'b0;
        end

        tick();
        tick();
        settle();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port unified instruction/data memory between the multi-cycle core and the program loader/debug port. Core fetches, loads and stores (issued from FETCH, MEM_READ and MEM_WRITE) and loader writes/readbacks both request through it. It grants one access at a time and tracks the single outstanding read until data returns. Responses are routed back to the owning port, and a loader lock supports uninterrupted image downloads.

## Interface
- `ADDR_W`, 32: byte-address width of both request ports.
- `DATA_W`, 32: data width; memory is word-organised, `DATA_W/8` byte lanes.
- `RD_LAT`, 1: memory read latency in cycles, 1..3.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `p0_req` in 1: core request valid; held until `p0_gnt`.
- `p0_we` in 1: core write (1) / read (0).
- `p0_addr` in ADDR_W: core byte address.
- `p0_wdata` in DATA_W: core write data.
- `p0_wmask` in DATA_W/8: core byte-lane write enables.
- `p0_gnt` out 1: core request accepted this cycle.
- `p0_rvalid` out 1: core read data valid.
- `p0_rdata` out DATA_W: core read data.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_wmask`, `p1_gnt`, `p1_rvalid`, `p1_rdata`: loader port, same meanings.
- `p1_lock` in 1: loader requests exclusive ownership while high.
- `mem_en` out 1: memory command strobe.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W-2: word address, equal to `addr[ADDR_W-1:2]`.
- `mem_wdata` out DATA_W: write data.
- `mem_wmask` out DATA_W/8: byte enables.
- `mem_rdata` in DATA_W: read data, valid `RD_LAT` cycles after the read command.
- `busy` out 1: read outstanding or lock held.

## Operation
- States: IDLE, RD_WAIT, LOCKED.
- Accept: `pX_gnt = pX_req && eligible`. On accept, `mem_*` mirror that port's fields in the same cycle, and `mem_en=1`.
- Eligible conditions:
  - Nothing is eligible in RD_WAIT, except on its final cycle.
  - In LOCKED, only p1 is eligible.
- Arbitration when both request: round-robin on `last_gnt`. The port not granted last wins. Reset value of `last_gnt` is p1, so p0 wins the first tie.
- Read accept: go to RD_WAIT, load counter with `RD_LAT`, and record owner.
  - Counter decrements every cycle.
  - At count 1, `owner_rvalid=1` and `owner_rdata=mem_rdata`. The other port's `rvalid` stays 0.
  - A new request may be accepted in that same cycle (back-to-back reads).
- Write accept: completes in one cycle with no response. Back-to-back writes at one per cycle are allowed.
- Lock:
  - A p1 grant with `p1_lock=1` enters LOCKED after any read completes.
  - LOCKED exits to IDLE on the first cycle `p1_lock=0` with no read outstanding.
  - p0 requests stall without being dropped.
  - `p1_lock` without a p1 grant has no effect.
- Outside a grant, `rdata` outputs are 0. `mem_*` fields are 0 when `mem_en=0`.
- `addr[1:0]` is ignored. Sub-word alignment is the requester's job via `wmask`.

## Timing
- Reset (async assert, synchronous deassert): state IDLE, counter 0, `last_gnt`=p1, and every output 0.
- Grant and `mem_en` are combinational from `req` and registered state, so there is zero added latency.
- Read response arrives exactly `RD_LAT` cycles after the grant cycle.
- Maximum read throughput is 1 per `RD_LAT` cycles. Write throughput is 1 per cycle.
- Simultaneous read completion and new request: response is delivered and the new request is granted in the same cycle.
- Reset during RD_WAIT: the pending `rvalid` is never issued.
- A requester dropping `req` before `gnt` is a protocol violation. The bench flags it with an assertion.

## Structure
- `mem_arb_pkg` holds:
  - `arb_state_e` (IDLE/RD_WAIT/LOCKED).
  - `port_id_e` (P_CORE=0, P_LOADER=1).
  - A request struct bundling `we`/`addr`/`wdata`/`wmask`.
  - The `RD_LAT` bound constant.
- Sub-module `mem_rd_tracker` holds the latency counter and owner register, producing `rd_done` and `rd_owner`.
- The top level holds the arbitration, lock FSM and muxes.

## Test plan
- Core read only at `0x0000_0010`, `RD_LAT=2`, memory returns `0xDEAD_BEEF` → `p0_gnt` in cycle 0, `mem_addr=0x4`, `p0_rvalid` with `0xDEAD_BEEF` in cycle 2, `p1_rvalid` stays 0.
- Both ports read from reset → p0 granted first. p1 is granted in p0's `rvalid` cycle. Responses are routed to the correct ports in order.
- Loader holds `p1_lock` for 4 writes of 0x11..0x44 at 0x100..0x10C while the core requests a read → 4 consecutive `p1_gnt`, `mem_we=1`, `p0_gnt` low throughout. `p0_gnt` asserts in the cycle after the lock is dropped.
- Continuous contention with writes on both ports → grants alternate p0, p1, p0, p1, one per cycle.
- Assert `reset` in the middle of RD_WAIT of a p1 read (`RD_LAT=3`) → all outputs 0 immediately. No `p1_rvalid` after release. The first tie after reset goes to p0.
- `p0_wmask=4'b0100`, `wdata=0x00AB_0000` → `mem_wmask=4'b0100` and `mem_wdata=0x00AB_0000` in the grant cycle.
